// File: rtl/game_judge.sv
// N x N, K-in-a-row game-status engine: tracks turn, scans the board one cell per cycle after
// each move for a K-line of the mover, and keeps game/win counters.
//   state    | meaning
//   ST_TURN1 | P1 to move
//   ST_TURN2 | P2 to move
//   ST_DRAW  | board full, no winner
//   ST_WIN1  | P1 has won
//   ST_WIN2  | P2 has won
//   ST_SCAN  | checking cells of the snapshot for a mover line
module game_judge #(
    parameter int N         = 3,
    parameter int K         = 3,
    parameter int CNT_W     = 4,
    parameter int SCORE_W   = 4,
    parameter int ALT_START = 0
) (
    input  logic               clk_gj,
    input  logic               rst_gj,
    input  logic               move_gj,
    input  logic               new_game_gj,
    input  logic [N*N-1:0]     p1_grid_gj,
    input  logic [N*N-1:0]     p2_grid_gj,
    output logic [2:0]         state_gj,
    output logic               busy_gj,
    output logic               done_gj,
    output logic [CNT_W-1:0]   game_cnt_gj,
    output logic [SCORE_W-1:0] p1_wins_gj,
    output logic [SCORE_W-1:0] p2_wins_gj
);
    localparam int CELLS = N * N;
    localparam int IDX_W = $clog2(CELLS);
    localparam int RC_W  = $clog2(N);

    typedef enum logic [2:0] {
        ST_TURN1 = 3'd0,
        ST_TURN2 = 3'd1,
        ST_DRAW  = 3'd2,
        ST_WIN1  = 3'd3,
        ST_WIN2  = 3'd4,
        ST_SCAN  = 3'd5
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_starter, r_mover, r_done;
    logic [IDX_W-1:0]     r_idx;
    logic [RC_W-1:0]      r_row, r_col;
    logic [CELLS-1:0]     r_snap1, r_snap2;
    logic [CNT_W-1:0]     r_game_cnt;
    logic [SCORE_W-1:0]   r_p1_wins, r_p2_wins;

    logic [CELLS-1:0]     w_grid;
    logic [3:0]           w_line;
    logic                 w_hit, w_last, w_full;
    logic                 w_capture, w_step, w_exit, w_draw, w_win1, w_win2;

    // Directions: 0 right, 1 down, 2 down-right, 3 down-left.
    function automatic int dir_dr(input int d);
        return (d == 0) ? 0 : 1;
    endfunction

    function automatic int dir_dc(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            2:       return 1;
            default: return -1;
        endcase
    endfunction

    // Off-board cells read as empty, so lines that do not fit can never hit.
    function automatic logic cell_on(input logic [CELLS-1:0] g, input int r, input int c);
        if (r < 0 || r >= N || c < 0 || c >= N) return 1'b0;
        return g[r * N + c];
    endfunction

    always_comb begin
        w_grid = r_mover ? r_snap2 : r_snap1;
        w_line = '1;
        for (int d = 0; d < 4; d++) begin
            for (int t = 0; t < K; t++) begin
                if (!cell_on(w_grid, int'(r_row) + t * dir_dr(d), int'(r_col) + t * dir_dc(d)))
                    w_line[d] = 1'b0;
            end
        end
        w_hit  = |w_line;
        w_last = (r_idx == IDX_W'(CELLS - 1));
        w_full = &(r_snap1 | r_snap2);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_step      = 1'b0;
        w_exit      = 1'b0;
        w_draw      = 1'b0;
        w_win1      = 1'b0;
        w_win2      = 1'b0;
        if (new_game_gj) begin
            w_state_nxt = r_starter ? ST_TURN2 : ST_TURN1;
        end else begin
            case (r_state)
                ST_TURN1, ST_TURN2: begin
                    if (move_gj) begin
                        w_state_nxt = ST_SCAN;
                        w_capture   = 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (w_hit) begin
                        w_exit      = 1'b1;
                        w_win1      = ~r_mover;
                        w_win2      = r_mover;
                        w_state_nxt = r_mover ? ST_WIN2 : ST_WIN1;
                    end else if (w_last) begin
                        w_exit = 1'b1;
                        if (w_full) begin
                            w_draw      = 1'b1;
                            w_state_nxt = ST_DRAW;
                        end else begin
                            w_state_nxt = r_mover ? ST_TURN1 : ST_TURN2;
                        end
                    end else begin
                        w_step = 1'b1;
                    end
                end
                ST_DRAW, ST_WIN1, ST_WIN2: w_state_nxt = r_state;
                default:                   w_state_nxt = ST_TURN1;
            endcase
        end
    end

    always_ff @(posedge clk_gj) begin
        if (rst_gj) r_state <= ST_TURN1;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_gj) begin
        if (rst_gj) begin
            r_starter  <= 1'b0;
            r_mover    <= 1'b0;
            r_done     <= 1'b0;
            r_idx      <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_snap1    <= '0;
            r_snap2    <= '0;
            r_game_cnt <= '0;
            r_p1_wins  <= '0;
            r_p2_wins  <= '0;
        end else begin
            r_done <= w_exit;
            if (new_game_gj && ALT_START != 0) r_starter <= ~r_starter;
            if (w_capture) begin
                r_snap1 <= p1_grid_gj;
                r_snap2 <= p2_grid_gj;
                r_mover <= (r_state == ST_TURN2);
                r_idx   <= '0;
                r_row   <= '0;
                r_col   <= '0;
            end
            if (w_step) begin
                r_idx <= r_idx + 1'b1;
                if (r_col == RC_W'(N - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (w_draw || w_win1 || w_win2) r_game_cnt <= r_game_cnt + 1'b1;
            if (w_win1 && r_p1_wins != '1)  r_p1_wins  <= r_p1_wins + 1'b1;
            if (w_win2 && r_p2_wins != '1)  r_p2_wins  <= r_p2_wins + 1'b1;
        end
    end

    assign state_gj    = r_state;
    assign busy_gj     = (r_state == ST_SCAN);
    assign done_gj     = r_done;
    assign game_cnt_gj = r_game_cnt;
    assign p1_wins_gj  = r_p1_wins;
    assign p2_wins_gj  = r_p2_wins;
endmodule

// File: tb/tb_game_judge.sv
// Randomized game play against a board-level reference model; results are queued at move time
// and checked by a monitor whenever the judge pulses done.
module tb_game_judge;
    localparam int N = 4, K = 3, CNT_W = 3, SCORE_W = 2, ALT = 1;
    localparam int CELLS = N * N;

    logic               clk = 1'b0;
    logic               rst, move, newg;
    logic [CELLS-1:0]   g1, g2;
    logic [2:0]         st;
    logic               busy, done;
    logic [CNT_W-1:0]   gc;
    logic [SCORE_W-1:0] w1, w2;

    game_judge #(.N(N), .K(K), .CNT_W(CNT_W), .SCORE_W(SCORE_W), .ALT_START(ALT)) dut (
        .clk_gj(clk), .rst_gj(rst), .move_gj(move), .new_game_gj(newg),
        .p1_grid_gj(g1), .p2_grid_gj(g2), .state_gj(st), .busy_gj(busy), .done_gj(done),
        .game_cnt_gj(gc), .p1_wins_gj(w1), .p2_wins_gj(w2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int st;
        int at;
        int gc;
        int w1;
        int w2;
    } exp_t;
    exp_t q[$];
    exp_t e_mon;

    int errors = 0, checks = 0;
    int m_state, m_starter, m_gc, m_w1, m_w2;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Earliest start cell (row-major) of a K-line of marks in g, or -1.
    function automatic int first_win(input logic [CELLS-1:0] g);
        int dr[4] = '{0, 1, 1, 1};
        int dc[4] = '{1, 0, 1, -1};
        for (int s = 0; s < CELLS; s++) begin
            for (int d = 0; d < 4; d++) begin
                int er = s / N + (K - 1) * dr[d];
                int ec = s % N + (K - 1) * dc[d];
                bit ok = (er < N) && (ec >= 0) && (ec < N);
                for (int t = 0; t < K && ok; t++)
                    if (!g[(s / N + t * dr[d]) * N + (s % N + t * dc[d])]) ok = 0;
                if (ok) return s;
            end
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done pulse, expected none (cycle %0d)", cyc);
            end else begin
                e_mon = q.pop_front();
                chk("done_cycle", cyc, e_mon.at);
                chk("result_state", int'(st), e_mon.st);
                chk("game_cnt", int'(gc), e_mon.gc);
                chk("p1_wins", int'(w1), e_mon.w1);
                chk("p2_wins", int'(w2), e_mon.w2);
            end
        end
    end

    task automatic check_counters(input string tag);
        chk({tag, "_gc"}, int'(gc), m_gc);
        chk({tag, "_w1"}, int'(w1), m_w1);
        chk({tag, "_w2"}, int'(w2), m_w2);
    endtask

    task automatic do_new_game();
        newg = 1'b1;
        move = 1'($urandom_range(0, 1));
        g1   = CELLS'($urandom);
        g2   = CELLS'($urandom);
        @(negedge clk);
        newg = 1'b0;
        move = 1'b0;
        m_state   = m_starter;
        m_starter = m_starter ^ ALT;
        chk("newgame_state", int'(st), m_state);
        chk("newgame_done", int'(done), 0);
        check_counters("newgame");
    endtask

    task automatic do_move();
        logic [CELLS-1:0] gm, go;
        int mode, r, L, j, exp_st, c0, a;
        bit abort;
        mode = $urandom_range(0, 3);
        gm = '0;
        go = '0;
        for (int i = 0; i < CELLS; i++) begin
            r = $urandom_range(0, 99);
            case (mode)
                0: begin if (r < 25) gm[i] = 1'b1; else if (r < 50) go[i] = 1'b1; end
                1: begin if (r < 55) gm[i] = 1'b1; else if (r < 80) go[i] = 1'b1; end
                2: begin if (r < 30) gm[i] = 1'b1; else go[i] = 1'b1; end
                default: begin if (r < 50) gm[i] = 1'b1; else go[i] = 1'b1; end
            endcase
        end
        if (m_state == 0) begin g1 = gm; g2 = go; end
        else              begin g1 = go; g2 = gm; end
        j = first_win(gm);
        if (j >= 0) begin
            L = j + 1;
            exp_st = (m_state == 0) ? 3 : 4;
        end else begin
            L = CELLS;
            exp_st = (&(gm | go)) ? 2 : 1 - m_state;
        end
        abort = ($urandom_range(0, 7) == 0);
        a = $urandom_range(1, L);
        c0 = cyc;
        move = 1'b1;
        if (!abort) begin
            m_state = exp_st;
            if (exp_st >= 2) m_gc = (m_gc + 1) % (1 << CNT_W);
            if (exp_st == 3 && m_w1 < (1 << SCORE_W) - 1) m_w1++;
            if (exp_st == 4 && m_w2 < (1 << SCORE_W) - 1) m_w2++;
            q.push_back('{exp_st, c0 + 1 + L, m_gc, m_w1, m_w2});
        end
        for (int k = 1; k <= L; k++) begin
            @(negedge clk);
            chk("busy_scan", int'(busy), 1);
            move = 1'($urandom_range(0, 1));
            g1   = CELLS'($urandom);
            g2   = CELLS'($urandom);
            if (abort && k == a) begin
                newg = 1'b1;
                @(negedge clk);
                newg = 1'b0;
                move = 1'b0;
                m_state   = m_starter;
                m_starter = m_starter ^ ALT;
                chk("abort_state", int'(st), m_state);
                chk("abort_done", int'(done), 0);
                check_counters("abort");
                return;
            end
        end
        @(negedge clk);
        move = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        move = 1'b0;
        newg = 1'b0;
        g1   = '0;
        g2   = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", int'(st), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_gc", int'(gc), 0);
        chk("reset_w1", int'(w1), 0);
        chk("reset_w2", int'(w2), 0);
        rst = 1'b0;
        m_state = 0; m_starter = 0; m_gc = 0; m_w1 = 0; m_w2 = 0;
        for (int it = 0; it < 250; it++) begin
            @(negedge clk);
            if (m_state >= 2 || $urandom_range(0, 11) == 0) do_new_game();
            else                                            do_move();
        end
        repeat (4) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
